// File: rtl/sram_resp_pkg.sv
// Shared types and constants for the sram_resp responder, plus the physical-memory access hooks.
// Latency: none (types, constants and combinational access functions only).
// Backpressure: none; the v_pmem_* functions are backed by an in-package word store with call counters.
package sram_resp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [31:0] PMEM_BASE = 32'h8000_0000;
    localparam logic [31:0] PMEM_SIZE = 32'h0800_0000;
    localparam logic [7:0]  LFSR_SEED = 8'hA5;

    function automatic logic pmem_fault(input logic [31:0] addr);
        return (addr[1:0] != 2'b00) || (addr < PMEM_BASE) || (addr >= PMEM_BASE + PMEM_SIZE);
    endfunction

    int unsigned pmem_mem [int unsigned];
    int unsigned pmem_rd_cnt = 0;
    int unsigned pmem_wr_cnt = 0;

    function automatic int v_pmem_read(input int raddr);
        int unsigned key;
        key = 32'(raddr) & 32'hFFFF_FFFC;
        pmem_rd_cnt = pmem_rd_cnt + 1;
        return pmem_mem.exists(key) ? int'(pmem_mem[key]) : 0;
    endfunction

    function automatic void v_pmem_write(input int waddr, input int wdata, input byte wmask);
        int unsigned key;
        logic [31:0] word;
        logic [31:0] wd;
        key  = 32'(waddr) & 32'hFFFF_FFFC;
        word = pmem_mem.exists(key) ? pmem_mem[key] : 32'h0;
        wd   = 32'(wdata);
        for (int i = 0; i < 4; i++) begin
            if (wmask[i]) word[8*i +: 8] = wd[8*i +: 8];
        end
        pmem_mem[key] = word;
        pmem_wr_cnt = pmem_wr_cnt + 1;
    endfunction

endpackage

// File: rtl/sram_resp_lfsr8.sv
// 8-bit Fibonacci LFSR, x^8+x^6+x^5+x^4+1, free-running, seeded at reset.
// Latency: new value every cycle. No backpressure.
module lfsr8
    import sram_resp_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    output logic [7:0] lfsr
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lfsr <= LFSR_SEED;
        end else begin
            lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
        end
    end

endmodule

// File: rtl/sram_resp.sv
// Single-outstanding SRAM responder: LATENCY cycles from acceptance to resp_valid, one memory access per request.
// Backpressure: req_ready only in IDLE; the response is held stable until resp_ready. SRAM_RESP_RAND_DELAY_EN adds 0..3 random cycles.
module sram_resp
    import sram_resp_pkg::*;
#(
    parameter int unsigned LATENCY = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic        req_wen,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_wmask,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    state_t      state;
    logic [3:0]  cnt;
    logic [31:0] addr_q;
    logic        wen_q;
    logic [31:0] wdata_q;
    logic [3:0]  wmask_q;

    logic [4:0]  total_delay;
    logic [4:0]  delay_m1;
    logic [3:0]  cnt_load;
    logic        accept;
    logic        do_access;
    logic [31:0] acc_addr;
    logic [31:0] acc_addr_al;
    logic        acc_wen;
    logic [31:0] acc_wdata;
    logic [3:0]  acc_wmask;
    logic        acc_err;

`ifdef SRAM_RESP_RAND_DELAY_EN
    logic [7:0] lfsr;

    lfsr8 u_lfsr (
        .clk   (clk),
        .reset (reset),
        .lfsr  (lfsr)
    );

    assign total_delay = 5'(LATENCY) + {3'b000, lfsr[1:0]};
`else
    assign total_delay = 5'(LATENCY);
`endif

    assign req_ready  = (state == IDLE);
    assign resp_valid = (state == RESP);
    assign accept     = req_valid && req_ready;

    // The counter is only 4 bits; LATENCY=15 plus random extra saturates at 16 cycles.
    assign delay_m1 = total_delay - 5'd1;
    assign cnt_load = delay_m1[4] ? 4'hF : delay_m1[3:0];

    assign do_access = (accept && (cnt_load == 4'd0)) || ((state == WAIT) && (cnt == 4'd1));

    // A zero-wait access happens on the acceptance edge, before the latches hold the request.
    assign acc_addr    = (state == IDLE) ? req_addr  : addr_q;
    assign acc_wen     = (state == IDLE) ? req_wen   : wen_q;
    assign acc_wdata   = (state == IDLE) ? req_wdata : wdata_q;
    assign acc_wmask   = (state == IDLE) ? req_wmask : wmask_q;
    assign acc_addr_al = {acc_addr[31:2], 2'b00};
    assign acc_err     = pmem_fault(acc_addr);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= 4'd0;
            addr_q     <= 32'h0;
            wen_q      <= 1'b0;
            wdata_q    <= 32'h0;
            wmask_q    <= 4'h0;
            resp_rdata <= 32'h0;
            resp_err   <= 1'b0;
        end else begin
            if (do_access) begin
                if (acc_err) begin
                    resp_rdata <= 32'h0;
                    resp_err   <= 1'b1;
                end else if (acc_wen) begin
                    if (acc_wmask != 4'h0) begin
                        v_pmem_write(acc_addr_al, acc_wdata, {4'b0000, acc_wmask});
                    end
                    resp_rdata <= 32'h0;
                    resp_err   <= 1'b0;
                end else begin
                    resp_rdata <= v_pmem_read(acc_addr_al);
                    resp_err   <= 1'b0;
                end
            end

            case (state)
                IDLE: begin
                    if (accept) begin
                        addr_q  <= req_addr;
                        wen_q   <= req_wen;
                        wdata_q <= req_wdata;
                        wmask_q <= req_wmask;
                        cnt     <= cnt_load;
                        state   <= (cnt_load == 4'd0) ? RESP : WAIT;
                    end
                end
                WAIT: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) state <= RESP;
                end
                RESP: begin
                    if (resp_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
